eth_tx_arbiter: RTL and testbench

- Packet-level round-robin arbiter sharing one Ethernet transmit path (eth_framer → async packet FIFO → gmii_tx_mac) between NUM_INPUTS AXIS packet sources, e.g. the ARP engine and an IP/UDP transmitter.
- Each input carries per-packet sideband (dst_mac, ethertype).
- The arbiter grants one whole packet at a time and holds its sideband stable on the output for the framer until tlast completes.

---
 rtl/eth_tx_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// eth_tx_arbiter
//
// Packet-level round-robin arbiter that shares one Ethernet transmit path
// (framer -> packet FIFO -> MAC) between NUM_INPUTS AXI-Stream packet sources.
// A whole packet is granted at a time. The granted source's per-packet sideband
// (dst_mac, ethertype) is captured at grant time. It is held stable on the
// output until the packet's tlast handshake.
//
// Optional feature (compile-time macro ETH_TX_ARB_PRIORITY_EN):
//   defined   : input 0 has strict priority at every arbitration. Otherwise
//               round-robin runs over inputs 1..NUM_INPUTS-1.
//   undefined : pure round-robin over all inputs.
//   The port list is identical in both builds.
//
// Ports:
//   clk               sole clock
//   areset            asynchronous, active-high reset
//   axis_i_tready     per-input ready (only the granted input sees downstream ready)
//   axis_i_tvalid     per-input valid
//   axis_i_tlast      per-input last
//   axis_i_tkeep      per-input keep, input k at slice k
//   axis_i_tdata      per-input data, input k at slice k
//   axis_i_dst_mac    per-input destination MAC, valid while that tvalid is high
//   axis_i_ethertype  per-input ethertype, same validity as dst_mac
//   axis_o_tready     downstream ready
//   axis_o_tvalid     output valid (combinational from granted input)
//   axis_o_tlast      output last
//   axis_o_tkeep      output keep
//   axis_o_tdata      output data
//   axis_o_dst_mac    captured sideband of the granted packet
//   axis_o_ethertype  captured sideband of the granted packet
//   grant_valid       a packet is currently granted
//   grant_idx         index of the granted (or last granted) input
// -----------------------------------------------------------------------------
module eth_tx_arbiter #(
  parameter  int AXIS_BYTES = 4,
  parameter  int NUM_INPUTS = 2,
  localparam int GRANT_W    = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             areset,
  output logic [NUM_INPUTS-1:0]            axis_i_tready,
  input  logic [NUM_INPUTS-1:0]            axis_i_tvalid,
  input  logic [NUM_INPUTS-1:0]            axis_i_tlast,
  input  logic [NUM_INPUTS*AXIS_BYTES-1:0] axis_i_tkeep,
  input  logic [NUM_INPUTS*AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic [NUM_INPUTS*48-1:0]         axis_i_dst_mac,
  input  logic [NUM_INPUTS*16-1:0]         axis_i_ethertype,
  input  logic                             axis_o_tready,
  output logic                             axis_o_tvalid,
  output logic                             axis_o_tlast,
  output logic [AXIS_BYTES-1:0]            axis_o_tkeep,
  output logic [AXIS_BYTES*8-1:0]          axis_o_tdata,
  output logic [47:0]                      axis_o_dst_mac,
  output logic [15:0]                      axis_o_ethertype,
  output logic                             grant_valid,
  output logic [GRANT_W-1:0]               grant_idx
);

  localparam int DATA_W = AXIS_BYTES * 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0] grant_idx_q, grant_idx_d;
  logic               grant_valid_q, grant_valid_d;
  logic [47:0]        dst_mac_q, dst_mac_d;
  logic [15:0]        ethertype_q, ethertype_d;

  logic [GRANT_W-1:0] sel;
  logic               pkt_done;

  // First requester at or after ptr, wrapping through all inputs.
  function automatic logic [GRANT_W-1:0] rr_pick(
    input logic [NUM_INPUTS-1:0] req,
    input logic [GRANT_W-1:0]    ptr
  );
    int                 idx;
    logic [GRANT_W-1:0] idx_w;
    logic               found;
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      idx_w = idx[GRANT_W-1:0];
      if (!found && req[idx_w]) begin
        found   = 1'b1;
        rr_pick = idx_w;
      end
    end
  endfunction

  // Input 0 wins outright. Otherwise round-robin over 1..NUM_INPUTS-1.
  // A pointer of 0 is treated as 1 so that input 0 is never part of the rotation.
  function automatic logic [GRANT_W-1:0] prio_pick(
    input logic [NUM_INPUTS-1:0] req,
    input logic [GRANT_W-1:0]    ptr
  );
    int                 start;
    int                 idx;
    logic [GRANT_W-1:0] idx_w;
    logic               found;
    prio_pick = '0;
    found     = 1'b0;
    if (!req[0]) begin
      start = (ptr == '0) ? 1 : int'(ptr);
      for (int i = 0; i < NUM_INPUTS - 1; i++) begin
        idx = start + i;
        if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS + 1;
        idx_w = idx[GRANT_W-1:0];
        if (!found && req[idx_w]) begin
          found     = 1'b1;
          prio_pick = idx_w;
        end
      end
    end
  endfunction

`ifdef ETH_TX_ARB_PRIORITY_EN
  assign sel = prio_pick(axis_i_tvalid, rr_ptr_q);
`else
  assign sel = rr_pick(axis_i_tvalid, rr_ptr_q);
`endif

  // The packet ends on the granted input's tlast handshake.
  assign pkt_done = (state_q == GRANT) && axis_o_tvalid && axis_o_tready && axis_o_tlast;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    dst_mac_d     = dst_mac_q;
    ethertype_d   = ethertype_q;

    axis_i_tready = '0;
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = 1'b0;
    axis_o_tkeep  = '0;
    axis_o_tdata  = '0;

    case (state_q)
      IDLE: begin
        if (|axis_i_tvalid) begin
          grant_idx_d   = sel;
          dst_mac_d     = axis_i_dst_mac[int'(sel)*48 +: 48];
          ethertype_d   = axis_i_ethertype[int'(sel)*16 +: 16];
          grant_valid_d = 1'b1;
          state_d       = GRANT;
        end
      end

      GRANT: begin
        // Beats pass straight through. The grant holds even if the source
        // drops tvalid mid-packet.
        axis_o_tvalid              = axis_i_tvalid[grant_idx_q];
        axis_o_tlast               = axis_i_tlast[grant_idx_q];
        axis_o_tkeep               = axis_i_tkeep[int'(grant_idx_q)*AXIS_BYTES +: AXIS_BYTES];
        axis_o_tdata               = axis_i_tdata[int'(grant_idx_q)*DATA_W +: DATA_W];
        axis_i_tready[grant_idx_q] = axis_o_tready;

        if (pkt_done) begin
          if (int'(grant_idx_q) == NUM_INPUTS - 1) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_idx_q + 1'b1;
          end
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      dst_mac_q     <= '0;
      ethertype_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      dst_mac_q     <= dst_mac_d;
      ethertype_q   <= ethertype_d;
    end
  end

  assign axis_o_dst_mac   = dst_mac_q;
  assign axis_o_ethertype = ethertype_q;
  assign grant_valid      = grant_valid_q;
  assign grant_idx        = grant_idx_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
module tb_eth_tx_arbiter;

  localparam int AB = 4;
  localparam int N  = 2;
  localparam int DW = AB * 8;

  logic            clk = 1'b0;
  logic            areset;
  logic [N-1:0]    axis_i_tready;
  logic [N-1:0]    axis_i_tvalid;
  logic [N-1:0]    axis_i_tlast;
  logic [N*AB-1:0] axis_i_tkeep;
  logic [N*DW-1:0] axis_i_tdata;
  logic [N*48-1:0] axis_i_dst_mac;
  logic [N*16-1:0] axis_i_ethertype;
  logic            axis_o_tready;
  logic            axis_o_tvalid;
  logic            axis_o_tlast;
  logic [AB-1:0]   axis_o_tkeep;
  logic [DW-1:0]   axis_o_tdata;
  logic [47:0]     axis_o_dst_mac;
  logic [15:0]     axis_o_ethertype;
  logic            grant_valid;
  logic [0:0]      grant_idx;

  eth_tx_arbiter #(.AXIS_BYTES(AB), .NUM_INPUTS(N)) dut (
    .clk              (clk),
    .areset           (areset),
    .axis_i_tready    (axis_i_tready),
    .axis_i_tvalid    (axis_i_tvalid),
    .axis_i_tlast     (axis_i_tlast),
    .axis_i_tkeep     (axis_i_tkeep),
    .axis_i_tdata     (axis_i_tdata),
    .axis_i_dst_mac   (axis_i_dst_mac),
    .axis_i_ethertype (axis_i_ethertype),
    .axis_o_tready    (axis_o_tready),
    .axis_o_tvalid    (axis_o_tvalid),
    .axis_o_tlast     (axis_o_tlast),
    .axis_o_tkeep     (axis_o_tkeep),
    .axis_o_tdata     (axis_o_tdata),
    .axis_o_dst_mac   (axis_o_dst_mac),
    .axis_o_ethertype (axis_o_ethertype),
    .grant_valid      (grant_valid),
    .grant_idx        (grant_idx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Source stimulus state. Beat data is {CAFE, input, beat count}, so a dropped
  // or duplicated beat changes the observed word.
  logic        en      [N];
  int          len     [N];
  int          beat    [N];
  logic [47:0] sb_mac  [N];
  logic [15:0] sb_et   [N];
  logic [47:0] ref_mac [N];
  logic [15:0] ref_et  [N];
  logic        o_rdy;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      logic last;
      last = ((beat[k] % len[k]) == len[k] - 1);
      axis_i_tvalid[k]              = en[k];
      axis_i_tlast[k]               = last;
      axis_i_tkeep[k*AB +: AB]      = last ? 4'h3 : 4'hF;
      axis_i_tdata[k*DW +: DW]      = {16'hCAFE, 8'(k), 8'(beat[k])};
      axis_i_dst_mac[k*48 +: 48]    = sb_mac[k];
      axis_i_ethertype[k*16 +: 16]  = sb_et[k];
    end
    axis_o_tready = o_rdy;
  endtask

  task automatic set_src(input int k, input logic e, input int l, input logic [47:0] m, input logic [15:0] t);
    en[k] = e; len[k] = l;
    sb_mac[k] = m; ref_mac[k] = m;
    sb_et[k] = t;  ref_et[k] = t;
  endtask

  // One clock cycle: drive at the falling edge, check, then let the rising edge
  // advance whichever source handshook.
  task automatic cyc(input string tag, input logic e_gv, input int e_idx, input logic e_tv,
                     input logic [31:0] e_data, input logic e_last, input logic [1:0] e_rdy);
    logic [N-1:0] hs;
    @(negedge clk);
    drive();
    #1;
    check_eq({tag, ".gv"}, grant_valid, e_gv);
    if (e_idx >= 0) check_eq({tag, ".idx"}, grant_idx, e_idx);
    if (e_gv && e_idx >= 0) begin
      check_eq({tag, ".mac"}, axis_o_dst_mac, ref_mac[e_idx]);
      check_eq({tag, ".et"}, axis_o_ethertype, ref_et[e_idx]);
    end
    check_eq({tag, ".tv"}, axis_o_tvalid, e_tv);
    if (e_tv) begin
      check_eq({tag, ".data"}, axis_o_tdata, e_data);
      check_eq({tag, ".last"}, axis_o_tlast, e_last);
      check_eq({tag, ".keep"}, axis_o_tkeep, e_last ? 4'h3 : 4'hF);
    end
    check_eq({tag, ".rdy"}, axis_i_tready, e_rdy);
    hs = axis_i_tvalid & axis_i_tready;
    @(posedge clk);
    for (int k = 0; k < N; k++) if (hs[k]) beat[k]++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset = 1'b1;
    for (int k = 0; k < N; k++) begin
      en[k] = 1'b0; beat[k] = 0;
    end
    drive();
    #1;
    check_eq("rst.gv", grant_valid, 1'b0);
    check_eq("rst.idx", grant_idx, 1'b0);
    check_eq("rst.tv", axis_o_tvalid, 1'b0);
    check_eq("rst.rdy", axis_i_tready, 2'b00);
    check_eq("rst.mac", axis_o_dst_mac, 48'h0);
    check_eq("rst.et", axis_o_ethertype, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    o_rdy  = 1'b1;
    for (int k = 0; k < N; k++) begin
      en[k] = 1'b0; len[k] = 1; beat[k] = 0;
      sb_mac[k] = '0; sb_et[k] = '0; ref_mac[k] = '0; ref_et[k] = '0;
    end
    drive();

    // Only input 1 valid: ARP-style broadcast packet, 3 beats.
    do_reset();
    set_src(1, 1'b1, 3, 48'hFFFF_FFFF_FFFF, 16'h0806);
    o_rdy = 1'b1;
    cyc("t1.idle0", 1'b0, 0, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t1.b0",    1'b1, 1, 1'b1, 32'hCAFE_0100, 1'b0, 2'b10);
    cyc("t1.b1",    1'b1, 1, 1'b1, 32'hCAFE_0101, 1'b0, 2'b10);
    cyc("t1.b2",    1'b1, 1, 1'b1, 32'hCAFE_0102, 1'b1, 2'b10);
    en[1] = 1'b0;
    cyc("t1.idle1", 1'b0, 1, 1'b0, 32'h0, 1'b0, 2'b00);

`ifndef ETH_TX_ARB_PRIORITY_EN
    // Both inputs continuously valid, 2-beat packets: alternation 0,1,0,1.
    do_reset();
    set_src(0, 1'b1, 2, 48'h0200_0000_0A00, 16'h0800);
    set_src(1, 1'b1, 2, 48'h0200_0000_0B01, 16'h86DD);
    cyc("t2.i0", 1'b0, 0, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t2.a0", 1'b1, 0, 1'b1, 32'hCAFE_0000, 1'b0, 2'b01);
    cyc("t2.a1", 1'b1, 0, 1'b1, 32'hCAFE_0001, 1'b1, 2'b01);
    cyc("t2.i1", 1'b0, 0, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t2.b0", 1'b1, 1, 1'b1, 32'hCAFE_0100, 1'b0, 2'b10);
    cyc("t2.b1", 1'b1, 1, 1'b1, 32'hCAFE_0101, 1'b1, 2'b10);
    cyc("t2.i2", 1'b0, 1, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t2.a2", 1'b1, 0, 1'b1, 32'hCAFE_0002, 1'b0, 2'b01);
    cyc("t2.a3", 1'b1, 0, 1'b1, 32'hCAFE_0003, 1'b1, 2'b01);
    cyc("t2.i3", 1'b0, 0, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t2.b2", 1'b1, 1, 1'b1, 32'hCAFE_0102, 1'b0, 2'b10);
`endif

    // Backpressure 1,0,0,1 on input 0; input 1 arrives mid-packet and
    // input 0's live sideband changes; neither disturbs the granted packet.
    do_reset();
    set_src(0, 1'b1, 3, 48'h0200_0000_0A00, 16'h0800);
    set_src(1, 1'b0, 2, 48'h0200_0000_0B01, 16'h86DD);
    o_rdy = 1'b1;
    cyc("t3.i0", 1'b0, 0, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t3.a0", 1'b1, 0, 1'b1, 32'hCAFE_0000, 1'b0, 2'b01);
    o_rdy = 1'b0; en[1] = 1'b1;
    sb_mac[0] = 48'h1234_5678_9ABC; sb_et[0] = 16'hBEEF;
    cyc("t3.s0", 1'b1, 0, 1'b1, 32'hCAFE_0001, 1'b0, 2'b00);
    cyc("t3.s1", 1'b1, 0, 1'b1, 32'hCAFE_0001, 1'b0, 2'b00);
    o_rdy = 1'b1;
    cyc("t3.a1", 1'b1, 0, 1'b1, 32'hCAFE_0001, 1'b0, 2'b01);
    cyc("t3.a2", 1'b1, 0, 1'b1, 32'hCAFE_0002, 1'b1, 2'b01);
    en[0] = 1'b0;
    cyc("t3.i1", 1'b0, 0, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t3.b0", 1'b1, 1, 1'b1, 32'hCAFE_0100, 1'b0, 2'b10);
    cyc("t3.b1", 1'b1, 1, 1'b1, 32'hCAFE_0101, 1'b1, 2'b10);
    en[1] = 1'b0;
    cyc("t3.i2", 1'b0, 1, 1'b0, 32'h0, 1'b0, 2'b00);

`ifndef ETH_TX_ARB_PRIORITY_EN
    // Single-beat packets: one-cycle grants, alternation and pointer wrap.
    do_reset();
    set_src(0, 1'b1, 1, 48'h0200_0000_0A00, 16'h0800);
    set_src(1, 1'b1, 1, 48'h0200_0000_0B01, 16'h86DD);
    o_rdy = 1'b1;
    cyc("t4.i0", 1'b0, 0, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t4.a0", 1'b1, 0, 1'b1, 32'hCAFE_0000, 1'b1, 2'b01);
    cyc("t4.i1", 1'b0, 0, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t4.b0", 1'b1, 1, 1'b1, 32'hCAFE_0100, 1'b1, 2'b10);
    cyc("t4.i2", 1'b0, 1, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t4.a1", 1'b1, 0, 1'b1, 32'hCAFE_0001, 1'b1, 2'b01);
`endif

    // Asynchronous reset during beat 2 of a 4-beat packet.
    do_reset();
    set_src(0, 1'b1, 4, 48'h0200_0000_0A00, 16'h0800);
    set_src(1, 1'b0, 4, 48'h0200_0000_0B01, 16'h86DD);
    o_rdy = 1'b1;
    cyc("t5.i0", 1'b0, 0, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t5.a0", 1'b1, 0, 1'b1, 32'hCAFE_0000, 1'b0, 2'b01);
    @(negedge clk);
    drive();
    #1;
    check_eq("t5.pre.tv", axis_o_tvalid, 1'b1);
    check_eq("t5.pre.data", axis_o_tdata, 32'hCAFE_0001);
    areset = 1'b1;
    #1;
    check_eq("t5.ar.tv", axis_o_tvalid, 1'b0);
    check_eq("t5.ar.rdy", axis_i_tready, 2'b00);
    check_eq("t5.ar.gv", grant_valid, 1'b0);
    check_eq("t5.ar.mac", axis_o_dst_mac, 48'h0);
    check_eq("t5.ar.et", axis_o_ethertype, 16'h0);
    @(posedge clk);
    @(negedge clk);
    beat[0] = 0; beat[1] = 0;
    en[0] = 1'b1; en[1] = 1'b1;
    drive();
    #1;
    areset = 1'b0;
    #1;
    check_eq("t5.rel.gv", grant_valid, 1'b0);
    check_eq("t5.rel.tv", axis_o_tvalid, 1'b0);
    cyc("t5.win", 1'b1, 0, 1'b1, 32'hCAFE_0000, 1'b0, 2'b01);

`ifdef ETH_TX_ARB_PRIORITY_EN
    // Strict priority for input 0; input 1 only when 0 is idle; no pre-emption.
    do_reset();
    set_src(0, 1'b1, 2, 48'h0200_0000_0A00, 16'h0800);
    set_src(1, 1'b1, 2, 48'h0200_0000_0B01, 16'h86DD);
    o_rdy = 1'b1;
    cyc("t6.i0", 1'b0, 0, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t6.a0", 1'b1, 0, 1'b1, 32'hCAFE_0000, 1'b0, 2'b01);
    cyc("t6.a1", 1'b1, 0, 1'b1, 32'hCAFE_0001, 1'b1, 2'b01);
    cyc("t6.i1", 1'b0, 0, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t6.a2", 1'b1, 0, 1'b1, 32'hCAFE_0002, 1'b0, 2'b01);
    cyc("t6.a3", 1'b1, 0, 1'b1, 32'hCAFE_0003, 1'b1, 2'b01);
    en[0] = 1'b0;
    cyc("t6.i2", 1'b0, 0, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t6.b0", 1'b1, 1, 1'b1, 32'hCAFE_0100, 1'b0, 2'b10);
    en[0] = 1'b1;
    cyc("t6.b1", 1'b1, 1, 1'b1, 32'hCAFE_0101, 1'b1, 2'b10);
    cyc("t6.i3", 1'b0, 1, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc("t6.a4", 1'b1, 0, 1'b1, 32'hCAFE_0004, 1'b0, 2'b01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
